// File: rtl/labs_search_unit.sv
// Exhaustive LABS search: walks every sequence under a fixed prefix, accumulates the
// aperiodic-autocorrelation energy one lag per clock and keeps the lowest-energy sequence.
module labs_search_unit #(
    parameter int SEQ_WIDTH    = 8,
    parameter int E_WIDTH      = 16,
    parameter int PREFIX_WIDTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [6:0]         i_offset,
    output logic [71:0]        o_seq,
    output logic [E_WIDTH-1:0] o_e,
    output logic               o_done,
    output logic [2:0]         o_state
);

    localparam int FREE = SEQ_WIDTH - PREFIX_WIDTH;
    localparam int KW   = $clog2(SEQ_WIDTH) + 1;
    // Holds (N-1)*(N-1)^2 without wrapping for every legal N.
    localparam int AW   = 3 * $clog2(SEQ_WIDTH + 1) + 1;
    localparam int MW   = (AW > E_WIDTH) ? AW : E_WIDTH;
    localparam logic [KW-1:0] K_LAST = KW'(SEQ_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EVAL = 3'd2,
        S_CMP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [PREFIX_WIDTH-1:0] prefix_q, prefix_d;
    logic [FREE-1:0]         cnt_q, cnt_d;
    logic [SEQ_WIDTH-1:0]    cand_q, cand_d;
    logic [KW-1:0]           k_q, k_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic [SEQ_WIDTH-1:0]    best_q, best_d;
    logic [E_WIDTH-1:0]      e_q, e_d;
    logic                    done_q, done_d;

    logic [SEQ_WIDTH-1:0]    diff;
    int                      pop;
    int                      c_k;
    logic [AW-1:0]           sq;
    logic [MW-1:0]           acc_ext;
    logic [E_WIDTH-1:0]      acc_sat;
    logic                    unused_offset_bits;

    assign unused_offset_bits = ^i_offset;

    // C_k from the count of disagreeing pairs among the N-k overlapping positions.
    always_comb begin
        diff = cand_q ^ (cand_q >> k_q);
        pop  = 0;
        for (int i = 0; i < SEQ_WIDTH; i++) begin
            if ((i < (SEQ_WIDTH - int'(k_q))) && diff[i]) begin
                pop = pop + 1;
            end
        end
        c_k = (SEQ_WIDTH - int'(k_q)) - 2 * pop;
        sq  = AW'(c_k * c_k);
    end

    always_comb begin
        acc_ext = MW'(acc_q);
        acc_sat = ((acc_ext >> E_WIDTH) != '0) ? '1 : acc_ext[E_WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        prefix_d = prefix_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        k_d      = k_q;
        acc_d    = acc_q;
        best_d   = best_q;
        e_d      = e_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE: begin
                prefix_d = i_offset[PREFIX_WIDTH-1:0];
                cnt_d    = '0;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                cand_d  = {prefix_q, cnt_q};
                acc_d   = '0;
                k_d     = KW'(1);
                state_d = S_EVAL;
            end
            S_EVAL: begin
                acc_d = acc_q + sq;
                k_d   = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                // Strict compare so the earliest candidate wins a tie.
                if (acc_sat < e_q) begin
                    best_d = cand_q;
                    e_d    = acc_sat;
                end
                if (&cnt_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + FREE'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            prefix_q <= '0;
            cnt_q    <= '0;
            cand_q   <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            best_q   <= '0;
            e_q      <= '1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prefix_q <= prefix_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            best_q   <= best_d;
            e_q      <= e_d;
            done_q   <= done_d;
        end
    end

    assign o_seq   = 72'(best_q);
    assign o_e     = e_q;
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_labs_search_unit.sv
// Directed bench for labs_search_unit: four parameterisations driven one after another,
// expected results from hand-computed N=4 energies and a sign-product energy model for N=8.
module tb_labs_search_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst_n;
    logic [6:0]  off [4];
    logic [71:0] seq [4];
    logic [2:0]  st  [4];
    logic [3:0]  done;
    logic [15:0] e_a, e_b, e_d;
    logic [2:0]  e_c;

    int checks = 0;
    int errors = 0;

    // a: N=4 P=1; b: N=4 P=3; c: N=4 P=3 E_WIDTH=3; d: N=8 P=4
    labs_search_unit #(.SEQ_WIDTH(4), .E_WIDTH(16), .PREFIX_WIDTH(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_offset(off[0]),
        .o_seq(seq[0]), .o_e(e_a), .o_done(done[0]), .o_state(st[0]));
    labs_search_unit #(.SEQ_WIDTH(4), .E_WIDTH(16), .PREFIX_WIDTH(3)) u_b (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_offset(off[1]),
        .o_seq(seq[1]), .o_e(e_b), .o_done(done[1]), .o_state(st[1]));
    labs_search_unit #(.SEQ_WIDTH(4), .E_WIDTH(3), .PREFIX_WIDTH(3)) u_c (
        .i_clk(clk), .i_rst_n(rst_n[2]), .i_offset(off[2]),
        .o_seq(seq[2]), .o_e(e_c), .o_done(done[2]), .o_state(st[2]));
    labs_search_unit #(.SEQ_WIDTH(8), .E_WIDTH(16), .PREFIX_WIDTH(4)) u_d (
        .i_clk(clk), .i_rst_n(rst_n[3]), .i_offset(off[3]),
        .o_seq(seq[3]), .o_e(e_d), .o_done(done[3]), .o_state(st[3]));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int energy(input int x, input int n);
        int e, c, si, sj;
        e = 0;
        for (int k = 1; k < n; k++) begin
            c = 0;
            for (int i = 0; i < n - k; i++) begin
                si = ((x >> i) & 1) ? 1 : -1;
                sj = ((x >> (i + k)) & 1) ? 1 : -1;
                c += si * sj;
            end
            e += c * c;
        end
        return e;
    endfunction

    int   g_e, g_seq, ev;
    logic hold_bad;

    initial begin
        rst_n = 4'b0000;
        for (int i = 0; i < 4; i++) off[i] = 7'd0;
        tick(2);

        // Reset state of the N=4 P=1 unit
        check("a_rst_seq", seq[0], 72'h0);
        check("a_rst_e", e_a, 16'hFFFF);
        check("a_rst_done", done[0], 1'b0);
        check("a_rst_state", st[0], 3'd0);

        // offset 0: candidates 0..7, min E=2 at 0x1 (tie with 0x2, 0x4, 0x7)
        rst_n[0] = 1'b1;
        tick(40);
        check("a0_done_edge40", done[0], 1'b0);
        tick(1);
        check("a0_done_edge41", done[0], 1'b1);
        check("a0_seq", seq[0], 72'h1);
        check("a0_e", e_a, 16'd2);
        check("a0_state", st[0], 3'd4);

        hold_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (seq[0] !== 72'h1 || e_a !== 16'd2 || done[0] !== 1'b1) hold_bad = 1'b1;
        end
        check("a_hold_stable", hold_bad, 1'b0);
        check("a_hold_seq", seq[0], 72'h1);

        // Reset out of DONE, then offset 1: candidates 0x8..0xF
        rst_n[0] = 1'b0;
        off[0] = 7'd1;
        tick(1);
        check("a_rst_from_done_seq", seq[0], 72'h0);
        check("a_rst_from_done_e", e_a, 16'hFFFF);
        check("a_rst_from_done_done", done[0], 1'b0);
        rst_n[0] = 1'b1;
        tick(41);
        check("a1_done", done[0], 1'b1);
        check("a1_seq", seq[0], 72'h8);
        check("a1_e", e_a, 16'd2);

        // Mid-run reset: after edge 11 candidates 0x0 (E=14) and 0x1 (E=2) are done
        rst_n[0] = 1'b0;
        off[0] = 7'd0;
        tick(1);
        rst_n[0] = 1'b1;
        tick(11);
        check("a_mid_seq", seq[0], 72'h1);
        check("a_mid_e", e_a, 16'd2);
        check("a_mid_done", done[0], 1'b0);
        rst_n[0] = 1'b0;
        tick(1);
        check("a_mid_rst_seq", seq[0], 72'h0);
        check("a_mid_rst_e", e_a, 16'hFFFF);
        check("a_mid_rst_state", st[0], 3'd0);
        rst_n[0] = 1'b1;
        tick(40);
        check("a_restart_edge40", done[0], 1'b0);
        tick(1);
        check("a_restart_edge41", done[0], 1'b1);
        check("a_restart_seq", seq[0], 72'h1);
        check("a_restart_e", e_a, 16'd2);

        // Offset change after IDLE is ignored
        rst_n[0] = 1'b0;
        off[0] = 7'd0;
        tick(1);
        rst_n[0] = 1'b1;
        tick(5);
        off[0] = 7'd1;
        tick(36);
        check("a_offchg_done", done[0], 1'b1);
        check("a_offchg_seq", seq[0], 72'h1);
        check("a_offchg_e", e_a, 16'd2);
        rst_n[0] = 1'b0;

        // N=4 P=3 offset 7: 0xE (E=2), 0xF (E=14)
        off[1] = 7'b0000111;
        rst_n[1] = 1'b1;
        tick(10);
        check("b_done_edge10", done[1], 1'b0);
        tick(1);
        check("b_done", done[1], 1'b1);
        check("b_seq", seq[1], 72'hE);
        check("b_e", e_b, 16'd2);
        rst_n[1] = 1'b0;

        // E_WIDTH=3, offset 0: 0x0 has E=14 which saturates to 7 and must not replace o_e=7
        off[2] = 7'd0;
        rst_n[2] = 1'b1;
        tick(6);
        check("c_sat_first_seq", seq[2], 72'h0);
        check("c_sat_first_e", e_c, 3'd7);
        tick(5);
        check("c_sat_done", done[2], 1'b1);
        check("c_sat_seq", seq[2], 72'h1);
        check("c_sat_e", e_c, 3'd2);
        rst_n[2] = 1'b0;
        off[2] = 7'b0000111;
        tick(1);
        rst_n[2] = 1'b1;
        tick(11);
        check("c7_done", done[2], 1'b1);
        check("c7_seq", seq[2], 72'hE);
        check("c7_e", e_c, 3'd2);
        rst_n[2] = 1'b0;

        // N=8 P=4 offset 0 against the model, earliest tie
        g_e = 32'h7FFF_FFFF;
        g_seq = 0;
        for (int x = 0; x < 16; x++) begin
            ev = energy(x, 8);
            if (ev < g_e) begin
                g_e = ev;
                g_seq = x;
            end
        end
        off[3] = 7'd0;
        rst_n[3] = 1'b1;
        tick(144);
        check("d_done_edge144", done[3], 1'b0);
        tick(1);
        check("d_done_edge145", done[3], 1'b1);
        check("d_seq", seq[3], 72'(g_seq));
        check("d_e", e_d, 16'(g_e));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
